// File: rtl/hazard_tracker_pkg.sv
// Shared encodings for the D-stage hazard tracker: write sources, operand-use
// deadlines, forwarding selects and pipeline stage names.
package hazard_tracker_pkg;

    typedef enum logic [1:0] {
        WSRC_NONE = 2'd0,
        WSRC_ALU  = 2'd1,
        WSRC_MEM  = 2'd2,
        WSRC_PC   = 2'd3
    } wsrc_e;

    typedef enum logic [1:0] {
        TUSE_D    = 2'd0,
        TUSE_E    = 2'd1,
        TUSE_M    = 2'd2,
        TUSE_NONE = 2'd3
    } tuse_e;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_e;

    typedef enum logic [1:0] {
        STG_D = 2'd0,
        STG_E = 2'd1,
        STG_M = 2'd2,
        STG_W = 2'd3
    } stage_e;

    // Cycles, counted from entry into E, until the produced value exists.
    function automatic logic [1:0] tnew_at_entry(input logic [1:0] wsrc);
        case (wsrc_e'(wsrc))
            WSRC_ALU: return 2'd1;
            WSRC_MEM: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-read-port hazard check: finds the youngest in-flight producer of one
// D-stage source register and reports a stall request and a D forwarding select.
module hazard_match
    import hazard_tracker_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int TNEW_W = 2
) (
    input  logic [REG_W-1:0]  rd_i,
    input  logic [1:0]        tuse_i,
    input  logic              e_valid_i,
    input  logic [REG_W-1:0]  e_dest_i,
    input  logic [TNEW_W-1:0] e_tnew_i,
    input  logic              m_valid_i,
    input  logic [REG_W-1:0]  m_dest_i,
    input  logic [TNEW_W-1:0] m_tnew_i,
    input  logic              w_valid_i,
    input  logic [REG_W-1:0]  w_dest_i,
    input  logic [TNEW_W-1:0] w_tnew_i,
    output logic              stall_req_o,
    output logic [1:0]        d_sel_o
);

    logic live;
    assign live = (rd_i != '0) && (tuse_i != TUSE_NONE);

    // Priority E > M > W: a younger match shadows every older one.
    always_comb begin
        stall_req_o = 1'b0;
        d_sel_o     = FWD_GRF;
        if (live && e_valid_i && (e_dest_i == rd_i)) begin
            stall_req_o = int'(e_tnew_i) > int'(tuse_i);
            if (e_tnew_i == '0) d_sel_o = FWD_E;
        end else if (live && m_valid_i && (m_dest_i == rd_i)) begin
            stall_req_o = int'(m_tnew_i) > int'(tuse_i);
            if (m_tnew_i == '0) d_sel_o = FWD_M;
        end else if (live && w_valid_i && (w_dest_i == rd_i) && (w_tnew_i == '0)) begin
            d_sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// E/M/W producer scoreboard beside the pipeline registers; drives the D-stage
// stall and the D, E and M forwarding selects.
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int TNEW_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_read1,
    input  logic [REG_W-1:0] d_read2,
    input  logic [1:0]       d_tuse1,
    input  logic [1:0]       d_tuse2,
    input  logic [REG_W-1:0] d_dest,
    input  logic [1:0]       d_wsrc,
    output logic             stall,
    output logic [1:0]       d_fwd1,
    output logic [1:0]       d_fwd2,
    output logic [1:0]       e_fwd1,
    output logic [1:0]       e_fwd2,
    output logic             m_fwd2
);

    // *_ivalid marks a real instruction; *_valid marks a register producer.
    logic              e_ivalid_q, e_ivalid_d, e_valid_q, e_valid_d;
    logic [REG_W-1:0]  e_dest_q, e_dest_d, e_rs_q, e_rs_d, e_rt_q, e_rt_d;
    logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
    logic [1:0]        e_tuse1_q, e_tuse1_d, e_tuse2_q, e_tuse2_d;
    logic              m_ivalid_q, m_valid_q;
    logic [REG_W-1:0]  m_dest_q, m_rt_q;
    logic [TNEW_W-1:0] m_tnew_q;
    logic [1:0]        m_tuse2_q;
    logic              w_valid_q;
    logic [REG_W-1:0]  w_dest_q;
    logic [TNEW_W-1:0] w_tnew_q;
    logic              req1, req2;

    hazard_match #(.REG_W(REG_W), .TNEW_W(TNEW_W)) u_match1 (
        .rd_i(d_read1), .tuse_i(d_tuse1),
        .e_valid_i(e_valid_q), .e_dest_i(e_dest_q), .e_tnew_i(e_tnew_q),
        .m_valid_i(m_valid_q), .m_dest_i(m_dest_q), .m_tnew_i(m_tnew_q),
        .w_valid_i(w_valid_q), .w_dest_i(w_dest_q), .w_tnew_i(w_tnew_q),
        .stall_req_o(req1), .d_sel_o(d_fwd1)
    );

    hazard_match #(.REG_W(REG_W), .TNEW_W(TNEW_W)) u_match2 (
        .rd_i(d_read2), .tuse_i(d_tuse2),
        .e_valid_i(e_valid_q), .e_dest_i(e_dest_q), .e_tnew_i(e_tnew_q),
        .m_valid_i(m_valid_q), .m_dest_i(m_dest_q), .m_tnew_i(m_tnew_q),
        .w_valid_i(w_valid_q), .w_dest_i(w_dest_q), .w_tnew_i(w_tnew_q),
        .stall_req_o(req2), .d_sel_o(d_fwd2)
    );

    assign stall = d_valid && (req1 || req2);

    always_comb begin
        e_ivalid_d = 1'b0;
        e_valid_d  = 1'b0;
        e_dest_d   = '0;
        e_tnew_d   = '0;
        e_rs_d     = '0;
        e_rt_d     = '0;
        e_tuse1_d  = TUSE_NONE;
        e_tuse2_d  = TUSE_NONE;
        if (!stall) begin
            e_ivalid_d = d_valid;
            e_valid_d  = d_valid && (d_wsrc != WSRC_NONE) && (d_dest != '0);
            e_dest_d   = d_dest;
            e_tnew_d   = TNEW_W'(tnew_at_entry(d_wsrc));
            e_rs_d     = d_read1;
            e_rt_d     = d_read2;
            e_tuse1_d  = d_tuse1;
            e_tuse2_d  = d_tuse2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_ivalid_q <= 1'b0;
            e_valid_q  <= 1'b0;
            e_dest_q   <= '0;
            e_tnew_q   <= '0;
            e_rs_q     <= '0;
            e_rt_q     <= '0;
            e_tuse1_q  <= TUSE_NONE;
            e_tuse2_q  <= TUSE_NONE;
            m_ivalid_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_dest_q   <= '0;
            m_tnew_q   <= '0;
            m_rt_q     <= '0;
            m_tuse2_q  <= TUSE_NONE;
            w_valid_q  <= 1'b0;
            w_dest_q   <= '0;
            w_tnew_q   <= '0;
        end else begin
            e_ivalid_q <= e_ivalid_d;
            e_valid_q  <= e_valid_d;
            e_dest_q   <= e_dest_d;
            e_tnew_q   <= e_tnew_d;
            e_rs_q     <= e_rs_d;
            e_rt_q     <= e_rt_d;
            e_tuse1_q  <= e_tuse1_d;
            e_tuse2_q  <= e_tuse2_d;
            m_ivalid_q <= e_ivalid_q;
            m_valid_q  <= e_valid_q;
            m_dest_q   <= e_dest_q;
            m_tnew_q   <= (e_tnew_q != '0) ? e_tnew_q - TNEW_W'(1) : '0;
            m_rt_q     <= e_rt_q;
            m_tuse2_q  <= e_tuse2_q;
            w_valid_q  <= m_valid_q;
            w_dest_q   <= m_dest_q;
            w_tnew_q   <= (m_tnew_q != '0) ? m_tnew_q - TNEW_W'(1) : '0;
        end
    end

    // A not-yet-ready match in M shadows W, so the E operand waits instead.
    always_comb begin
        e_fwd1 = FWD_GRF;
        e_fwd2 = FWD_GRF;
        if (e_ivalid_q && (e_rs_q != '0) && (e_tuse1_q != TUSE_NONE)) begin
            if (m_valid_q && (m_dest_q == e_rs_q))
                e_fwd1 = (m_tnew_q == '0) ? FWD_M : FWD_GRF;
            else if (w_valid_q && (w_dest_q == e_rs_q) && (w_tnew_q == '0))
                e_fwd1 = FWD_W;
        end
        if (e_ivalid_q && (e_rt_q != '0) && (e_tuse2_q != TUSE_NONE)) begin
            if (m_valid_q && (m_dest_q == e_rt_q))
                e_fwd2 = (m_tnew_q == '0) ? FWD_M : FWD_GRF;
            else if (w_valid_q && (w_dest_q == e_rt_q) && (w_tnew_q == '0))
                e_fwd2 = FWD_W;
        end
    end

    assign m_fwd2 = m_ivalid_q && (m_rt_q != '0) && (m_tuse2_q != TUSE_NONE)
                 && w_valid_q && (w_dest_q == m_rt_q) && (w_tnew_q == '0);

endmodule

// File: tb/tb_hazard_tracker.sv
// Scenario bench for hazard_tracker: each row drives one D-stage instruction and
// queues the expected {stall, d_fwd1, d_fwd2, e_fwd1, e_fwd2, m_fwd2}.
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_read1, d_read2, d_dest;
    logic [1:0] d_tuse1, d_tuse2, d_wsrc;
    logic       stall, m_fwd2;
    logic [1:0] d_fwd1, d_fwd2, e_fwd1, e_fwd2;
    logic [9:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       v;
        logic [4:0] r1, r2, dst;
        logic [1:0] t1, t2, ws;
        logic [9:0] exp;
        string      name;
    } row_t;

    row_t sb[$];
    row_t got;

    hazard_tracker #(.REG_W(5), .TNEW_W(2)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_read1(d_read1), .d_read2(d_read2), .d_tuse1(d_tuse1), .d_tuse2(d_tuse2),
        .d_dest(d_dest), .d_wsrc(d_wsrc), .stall(stall),
        .d_fwd1(d_fwd1), .d_fwd2(d_fwd2), .e_fwd1(e_fwd1), .e_fwd2(e_fwd2),
        .m_fwd2(m_fwd2)
    );

    always #5 clk = ~clk;
    assign obs = {stall, d_fwd1, d_fwd2, e_fwd1, e_fwd2, m_fwd2};

    function automatic logic [9:0] mkexp(int s, int d1, int d2, int e1, int e2, int m2);
        return {1'(s), 2'(d1), 2'(d2), 2'(e1), 2'(e2), 1'(m2)};
    endfunction

    function automatic row_t mkrow(int v, int r1, int t1, int r2, int t2, int dst, int ws,
                                   logic [9:0] exp, string name);
        row_t r;
        r.v = 1'(v); r.r1 = 5'(r1); r.t1 = 2'(t1); r.r2 = 5'(r2); r.t2 = 2'(t2);
        r.dst = 5'(dst); r.ws = 2'(ws); r.exp = exp; r.name = name;
        return r;
    endfunction

    task automatic drive(input row_t r);
        d_valid = r.v; d_read1 = r.r1; d_tuse1 = r.t1; d_read2 = r.r2; d_tuse2 = r.t2;
        d_dest = r.dst; d_wsrc = r.ws;
    endtask

    task automatic flush();
        drive(mkrow(0, 0, 3, 0, 3, 0, 0, '0, "idle"));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(mkrow(0, 0, 3, 0, 3, 0, 0, '0, "idle"));
        #1;
        sb.push_back(mkrow(0, 0, 3, 0, 3, 0, 0, mkexp(0,0,0,0,0,0), "reset_idle"));
        got = sb.pop_front(); n_tests++;
        if (obs !== got.exp) begin n_fail++; $display("FAIL %s: observed %b required %b", got.name, obs, got.exp); end
        drive(mkrow(1, 3, 0, 3, 1, 7, 2, '0, "x"));
        sb.push_back(mkrow(1, 3, 0, 3, 1, 7, 2, mkexp(0,0,0,0,0,0), "reset_with_d"));
        @(negedge clk);
        got = sb.pop_front(); n_tests++;
        if (obs !== got.exp) begin n_fail++; $display("FAIL %s: observed %b required %b", got.name, obs, got.exp); end
        reset = 1'b0;
        flush();
    endtask

    task automatic run_rows(input row_t rows[$]);
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i]);
            @(negedge clk);
            got = sb.pop_front(); n_tests++;
            if (obs !== got.exp) begin n_fail++; $display("FAIL %s: observed %b required %b", got.name, obs, got.exp); end
            @(posedge clk); #1;
        end
        flush();
    endtask

    task automatic test_alu_branch();
        row_t rows[$];
        rows.push_back(mkrow(1, 1, 1, 2, 1, 3, 1, mkexp(0,0,0,0,0,0), "addu_enter"));
        rows.push_back(mkrow(1, 3, 0, 4, 0, 0, 0, mkexp(1,0,0,0,0,0), "beq_stall"));
        rows.push_back(mkrow(1, 3, 0, 4, 0, 0, 0, mkexp(0,2,0,0,0,0), "beq_fwd_m"));
        rows.push_back(mkrow(0, 0, 3, 0, 3, 0, 0, mkexp(0,0,0,3,0,0), "beq_e_from_w"));
        run_rows(rows);
    endtask

    task automatic test_load_use();
        row_t rows[$];
        rows.push_back(mkrow(1, 29, 1, 0, 3, 5, 2, mkexp(0,0,0,0,0,0), "lw_enter"));
        rows.push_back(mkrow(1, 5, 1, 6, 1, 7, 1, mkexp(1,0,0,0,0,0), "lw_use_stall"));
        rows.push_back(mkrow(1, 5, 1, 6, 1, 7, 1, mkexp(0,0,0,0,0,0), "lw_use_release"));
        rows.push_back(mkrow(0, 0, 3, 0, 3, 0, 0, mkexp(0,0,0,3,0,0), "lw_use_e_fwd_w"));
        run_rows(rows);
    endtask

    task automatic test_link();
        row_t rows[$];
        rows.push_back(mkrow(1, 0, 3, 0, 3, 31, 3, mkexp(0,0,0,0,0,0), "jal_enter"));
        rows.push_back(mkrow(1, 31, 0, 0, 3, 0, 0, mkexp(0,1,0,0,0,0), "jr_fwd_e"));
        rows.push_back(mkrow(0, 0, 3, 0, 3, 0, 0, mkexp(0,0,0,2,0,0), "jr_e_fwd_m"));
        run_rows(rows);
    endtask

    task automatic test_store_data();
        row_t rows[$];
        rows.push_back(mkrow(1, 29, 1, 0, 3, 2, 2, mkexp(0,0,0,0,0,0), "lw2_enter"));
        rows.push_back(mkrow(1, 29, 1, 2, 2, 0, 0, mkexp(0,0,0,0,0,0), "sw_no_stall"));
        rows.push_back(mkrow(0, 0, 3, 0, 3, 0, 0, mkexp(0,0,0,0,0,0), "sw_e_wait"));
        rows.push_back(mkrow(0, 0, 3, 0, 3, 0, 0, mkexp(0,0,0,0,0,1), "sw_m_fwd_w"));
        run_rows(rows);
    endtask

    task automatic test_zero_reg();
        row_t rows[$];
        rows.push_back(mkrow(1, 0, 1, 0, 3, 0, 1, mkexp(0,0,0,0,0,0), "ori_r0"));
        rows.push_back(mkrow(1, 0, 0, 0, 1, 9, 1, mkexp(0,0,0,0,0,0), "read_r0"));
        rows.push_back(mkrow(0, 0, 3, 0, 3, 0, 0, mkexp(0,0,0,0,0,0), "read_r0_e"));
        run_rows(rows);
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        rows.push_back(mkrow(1, 1, 1, 2, 1, 8, 1, mkexp(0,0,0,0,0,0), "addu8_enter"));
        rows.push_back(mkrow(0, 0, 3, 0, 3, 0, 0, mkexp(0,0,0,0,0,0), "gap"));
        rows.push_back(mkrow(1, 8, 0, 8, 0, 0, 0, mkexp(0,2,2,0,0,0), "same_reg_m"));
        rows.push_back(mkrow(1, 8, 0, 8, 0, 0, 0, mkexp(0,3,3,3,3,0), "same_reg_w"));
        run_rows(rows);
    endtask

    task automatic test_shadow();
        row_t rows[$];
        rows.push_back(mkrow(1, 1, 1, 2, 1, 8, 1, mkexp(0,0,0,0,0,0), "old_addu8"));
        rows.push_back(mkrow(1, 29, 1, 0, 3, 8, 2, mkexp(0,0,0,0,0,0), "young_lw8"));
        rows.push_back(mkrow(1, 8, 1, 0, 3, 10, 1, mkexp(1,0,0,0,0,0), "shadow_stall"));
        run_rows(rows);
    endtask

    task automatic test_reset_mid();
        drive(mkrow(1, 29, 1, 0, 3, 4, 2, '0, "lw4"));
        @(posedge clk); #1;
        drive(mkrow(1, 4, 1, 0, 3, 10, 1, '0, "dep"));
        sb.push_back(mkrow(1, 4, 1, 0, 3, 10, 1, mkexp(1,0,0,0,0,0), "pre_reset_stall"));
        #2;
        got = sb.pop_front(); n_tests++;
        if (obs !== got.exp) begin n_fail++; $display("FAIL %s: observed %b required %b", got.name, obs, got.exp); end
        reset = 1'b1;
        sb.push_back(mkrow(1, 4, 1, 0, 3, 10, 1, mkexp(0,0,0,0,0,0), "reset_drops_stall"));
        #1;
        got = sb.pop_front(); n_tests++;
        if (obs !== got.exp) begin n_fail++; $display("FAIL %s: observed %b required %b", got.name, obs, got.exp); end
        @(posedge clk); #2;
        reset = 1'b0;
        sb.push_back(mkrow(1, 4, 1, 0, 3, 10, 1, mkexp(0,0,0,0,0,0), "post_reset_read"));
        @(negedge clk);
        got = sb.pop_front(); n_tests++;
        if (obs !== got.exp) begin n_fail++; $display("FAIL %s: observed %b required %b", got.name, obs, got.exp); end
        @(posedge clk); #1;
        flush();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_branch();
        test_load_use();
        test_link();
        test_store_data();
        test_zero_reg();
        test_back_to_back();
        test_shadow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
